// File: rtl/envelope_engine_if.sv
// Request/response bundle between the sample feeder and the envelope engine.
// The feeder holds start until it sees idle_signal; fin_signal marks a valid result.
interface envelope_engine_if;
  logic        start;
  logic [31:0] sample_feed;
  logic        env_clear;
  logic        idle_signal;
  logic        fin_signal;
  logic [31:0] result;

  modport master (
    output start, sample_feed, env_clear,
    input  idle_signal, fin_signal, result
  );

  modport slave (
    input  start, sample_feed, env_clear,
    output idle_signal, fin_signal, result
  );
endinterface

// File: rtl/envelope_engine.sv
// Per-channel envelope follower: |x| tracked with fast attack / slow release, round-robin channels.
// Latency: accept edge k -> fin in cycle k+4, idle again k+5; start is ignored unless idle.
module envelope_engine #(
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 6,
  parameter int NUM_CH        = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  envelope_engine_if.slave  bus
);

  localparam int            CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, ABS, DIFF, SCALE, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        x_q, x_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        e_q, e_d;
  logic signed [32:0] d_q, d_d;
  logic [31:0]        result_q, result_d;
  logic [CW-1:0]      chan_q, chan_d;
  logic               clear_pend_q, clear_pend_d;
  logic [31:0]        env_q [NUM_CH];
  logic [31:0]        env_d [NUM_CH];

  logic [31:0]        abs_x;
  logic signed [32:0] d_shift;
  logic signed [33:0] sum;
  logic [31:0]        e_new;

  // The most negative sample has no positive twin; saturate it.
  always_comb begin
    if (x_q == 32'h8000_0000) begin
      abs_x = 32'h7FFF_FFFF;
    end else if (x_q[31]) begin
      abs_x = -x_q;
    end else begin
      abs_x = x_q;
    end
  end

  // Floor shift makes any negative difference move the envelope by at least 1.
  always_comb begin
    if (!d_q[32] && (d_q != '0)) begin
      d_shift = d_q >>> ATTACK_SHIFT;
    end else begin
      d_shift = d_q >>> RELEASE_SHIFT;
    end
    sum = $signed({2'b00, e_q}) + $signed({d_shift[32], d_shift});
    if (sum[33]) begin
      e_new = '0;
    end else if (sum[32:31] != 2'b00) begin
      e_new = 32'h7FFF_FFFF;
    end else begin
      e_new = sum[31:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    a_d          = a_q;
    e_d          = e_q;
    d_d          = d_q;
    result_d     = result_q;
    chan_d       = chan_q;
    clear_pend_d = clear_pend_q;
    env_d        = env_q;

    // A clear that cannot be applied right now waits for the end of the operation.
    if (bus.env_clear && !((state_q == IDLE) && !bus.start)) begin
      clear_pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.sample_feed;
          state_d = ABS;
        end else if (bus.env_clear) begin
          for (int i = 0; i < NUM_CH; i++) begin
            env_d[i] = '0;
          end
          chan_d = '0;
        end
      end
      ABS: begin
        a_d     = abs_x;
        e_d     = env_q[chan_q];
        state_d = DIFF;
      end
      DIFF: begin
        d_d     = $signed({1'b0, a_q}) - $signed({1'b0, e_q});
        state_d = SCALE;
      end
      SCALE: begin
        env_d[chan_q] = e_new;
        result_d      = e_new;
        state_d       = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (clear_pend_q || bus.env_clear) begin
          for (int i = 0; i < NUM_CH; i++) begin
            env_d[i] = '0;
          end
          chan_d       = '0;
          clear_pend_d = 1'b0;
        end else if (chan_q == LAST_CH) begin
          chan_d = '0;
        end else begin
          chan_d = chan_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      x_q          <= '0;
      a_q          <= '0;
      e_q          <= '0;
      d_q          <= '0;
      result_q     <= '0;
      chan_q       <= '0;
      clear_pend_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        env_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      a_q          <= a_d;
      e_q          <= e_d;
      d_q          <= d_d;
      result_q     <= result_d;
      chan_q       <= chan_d;
      clear_pend_q <= clear_pend_d;
      env_q        <= env_d;
    end
  end

  assign bus.idle_signal = (state_q == IDLE);
  assign bus.fin_signal  = (state_q == DONE);
  assign bus.result      = result_q;

endmodule

// File: tb/tb_envelope_engine.sv
// Bench for envelope_engine: vector table plus hand-built sequences for clear and reset corners.
// Expected results are queued at drive time and popped when fin_signal is seen.
module tb_envelope_engine;

  logic CLK;
  logic RESET_N;
  envelope_engine_if bus ();

  envelope_engine #(
    .ATTACK_SHIFT (2),
    .RELEASE_SHIFT(6),
    .NUM_CH       (4)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] sample;
    logic        pre_clr;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          fin_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET_N && bus.fin_signal) begin
      fin_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_fin", 32'd1, 32'd0);
      end else begin
        check("result", bus.result, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; drives one request and checks latency and idle return.
  task automatic run_op(input logic [31:0] s, input logic [31:0] exp, input logic clr_with);
    int t;
    int lat;
    t = 0;
    while (!bus.idle_signal && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("idle_before", 32'(bus.idle_signal), 32'd1);
    bus.start       = 1'b1;
    bus.sample_feed = s;
    bus.env_clear   = clr_with;
    exp_q.push_back(exp);
    @(negedge CLK);
    bus.start     = 1'b0;
    bus.env_clear = 1'b0;
    lat = 1;
    while (!bus.fin_signal && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    check("fin_latency", 32'(lat), 32'd4);
    @(negedge CLK);
    check("idle_after", 32'(bus.idle_signal), 32'd1);
    check("fin_single", 32'(bus.fin_signal), 32'd0);
  endtask

  task automatic do_clear();
    bus.env_clear = 1'b1;
    @(negedge CLK);
    bus.env_clear = 1'b0;
  endtask

  initial begin
    logic [31:0] cont_s [4];
    logic [31:0] cont_e [4];
    int          acc;
    int          t;
    int          fin0;

    tbl[0]  = '{32'h0000_1000, 1'b0, 32'h0000_0400};
    tbl[1]  = '{32'h0000_1000, 1'b0, 32'h0000_0400};
    tbl[2]  = '{32'h0000_1000, 1'b0, 32'h0000_0400};
    tbl[3]  = '{32'h0000_1000, 1'b0, 32'h0000_0400};
    tbl[4]  = '{32'h0000_0000, 1'b0, 32'h0000_03F0};
    tbl[5]  = '{32'h8000_0000, 1'b1, 32'h1FFF_FFFF};
    tbl[6]  = '{32'hFFFF_F000, 1'b0, 32'h0000_0400};
    tbl[7]  = '{32'h0000_0003, 1'b0, 32'h0000_0000};
    tbl[8]  = '{32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
    tbl[9]  = '{32'h7FFF_FFFF, 1'b0, 32'h37FF_FFFF};
    tbl[10] = '{32'h0000_03FF, 1'b0, 32'h0000_03FF};
    tbl[11] = '{32'h0000_0000, 1'b0, 32'h0000_0000};
    tbl[12] = '{32'h0000_0004, 1'b0, 32'h0000_0001};
    tbl[13] = '{32'h7FFF_FFFF, 1'b0, 32'h49FF_FFFF};
    cont_s = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};
    cont_e = '{32'h0000_0400, 32'h0000_0800, 32'h0000_0C00, 32'h0000_1000};

    RESET_N         = 1'b0;
    bus.start       = 1'b0;
    bus.sample_feed = '0;
    bus.env_clear   = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_idle", 32'(bus.idle_signal), 32'd1);
    check("rst_fin", 32'(bus.fin_signal), 32'd0);
    check("rst_result", bus.result, 32'd0);
    RESET_N = 1'b1;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].pre_clr) do_clear();
      run_op(tbl[i].sample, tbl[i].exp, 1'b0);
    end

    // Start held high across four operations; the pointer must wrap back to channel 0.
    do_clear();
    fin0      = fin_cnt;
    acc       = 0;
    t         = 0;
    bus.start = 1'b1;
    while (acc < 4 && t < 100) begin
      if (bus.idle_signal) begin
        bus.sample_feed = cont_s[acc];
        exp_q.push_back(cont_e[acc]);
        acc++;
      end
      @(negedge CLK);
      t++;
    end
    while (!bus.idle_signal && t < 100) begin
      @(negedge CLK);
      t++;
    end
    bus.start = 1'b0;
    check("cont_fins", 32'(fin_cnt - fin0), 32'd4);
    run_op(32'h0000_1000, 32'h0000_0700, 1'b0);

    // Clear raised during SCALE: this result is normal, the clear lands afterwards.
    bus.start       = 1'b1;
    bus.sample_feed = 32'h0000_1000;
    exp_q.push_back(32'h0000_0A00);
    @(negedge CLK);
    bus.start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    bus.env_clear = 1'b1;
    @(negedge CLK);
    bus.env_clear = 1'b0;
    check("scale_clr_fin", 32'(bus.fin_signal), 32'd1);
    @(negedge CLK);
    run_op(32'h0000_1000, 32'h0000_0400, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0);

    // Clear together with start: op proceeds, pointer restarts at 0 afterwards.
    run_op(32'h0000_1000, 32'h0000_0400, 1'b1);
    run_op(32'h0000_1000, 32'h0000_0400, 1'b0);
    run_op(32'h0000_1000, 32'h0000_0400, 1'b0);

    // Reset pulse while in DIFF abandons the operation.
    bus.start       = 1'b1;
    bus.sample_feed = 32'h0000_1000;
    @(negedge CLK);
    bus.start = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("midrst_idle", 32'(bus.idle_signal), 32'd1);
    check("midrst_fin", 32'(bus.fin_signal), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      run_op(32'h0000_1000, 32'h0000_0400, 1'b0);
    end

    repeat (3) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation still running at time limit, want finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/envelope_engine.md
ENVELOPE_ENGINE -- requirements
Module: envelope_engine

Interface
REQ-001 The module SHALL have parameters ATTACK_SHIFT, RELEASE_SHIFT and NUM_CH, listed below.
- ATTACK_SHIFT, 2, right-shift applied to a positive envelope difference.
- RELEASE_SHIFT, 6, right-shift applied to a negative envelope difference.
- NUM_CH, 4, number of channels, each with its own envelope; the channel pointer wraps at this count.

REQ-002 The module SHALL have the ports listed below.
- CLK  in  1  the single clock; all state updates on the rising edge.
- RESET_N  in  1  reset, asynchronous and active-low.
- start  in  1  request strobe from the sample feeder.
- sample_feed  in  32  signed two's-complement sample; valid while start=1.
- env_clear  in  1  request to zero all envelopes and the channel pointer.
- idle_signal  out  1  high when a request can be accepted.
- fin_signal  out  1  one-cycle pulse: result is valid.
- result  out  32  unsigned envelope of the channel just processed, in range [0, 0x7FFFFFFF].

Function
REQ-003 The FSM SHALL have the states IDLE, ABS, DIFF, SCALE and DONE.
REQ-004 idle_signal SHALL be 1 exactly when state=IDLE; it is decoded combinationally from the state register.
REQ-005 Accept: at a rising edge with state=IDLE and start=1, the block SHALL capture sample_feed into x_reg, and SHALL move IDLE->ABS.
REQ-006 When start=1 outside IDLE, the block SHALL ignore it with no side effect. The feeder holds start until it sees idle_signal=1.
REQ-007 ABS: the block SHALL compute a=|x_reg|, saturating 0x80000000 to 0x7FFFFFFF, and SHALL read e=env[chan]; ABS->DIFF.
REQ-008 DIFF: the block SHALL compute d=a-e as a 33-bit signed value; DIFF->SCALE.
REQ-009 SCALE: the block SHALL compute e_new = e + (d>>>ATTACK_SHIFT) when d>0, and e_new = e + (d>>>RELEASE_SHIFT) otherwise.
- The shift is arithmetic (floor).
- The sum is clamped to [0, 0x7FFFFFFF].
REQ-010 At the SCALE->DONE edge, the block SHALL write e_new to env[chan] and to result.
REQ-011 DONE: fin_signal SHALL be 1 for this single cycle. At the DONE->IDLE edge, chan SHALL become (chan+1) mod NUM_CH.
REQ-012 Latency: for start accepted at edge k, fin_signal SHALL be high in cycle k+4 and idle_signal SHALL be high again in cycle k+5.
REQ-013 result SHALL hold its value until the next SCALE->DONE edge.
REQ-014 A positive difference below 2^ATTACK_SHIFT adds 0 to the envelope; this is accepted behaviour.
REQ-015 A negative difference SHALL always move the envelope by at least 1 toward a.
REQ-016 env_clear handling:
- When env_clear=1 in IDLE with start=0, the block SHALL zero all env[] entries and chan at that edge.
- Otherwise the block SHALL set clear_pend.
- When clear_pend is set, the clear SHALL be applied at the DONE->IDLE edge. The clear overrides the pointer increment and the env write already committed, and it clears clear_pend.
REQ-017 When env_clear=1 and start=1 occur together in IDLE, the block SHALL accept the sample and defer the clear per REQ-016. fin_signal and result for that operation are unaffected.
REQ-018 Only positions 0..NUM_CH-1 of the channel pointer SHALL be reachable.

Reset
REQ-019 On RESET_N=0, asynchronously, the block SHALL force the following:
- state=IDLE, idle_signal=1, fin_signal=0;
- result=0, chan=0, x_reg=0, clear_pend=0;
- all env[] entries = 0.
REQ-020 When reset is asserted mid-operation, the block SHALL abandon the operation with no fin_signal pulse and no env write; after release it SHALL be in IDLE.
REQ-021 Reset deassertion is synchronised externally; after release the block SHALL accept start on the first rising edge.

Verification
REQ-022 After reset, start=1 with sample_feed=0x00001000 -> fin high 4 cycles later, result=0x00000400, idle high the cycle after fin.
REQ-023 Feed 0x00001000 to channels 0-3, then 0x00000000 on channel 0 -> results 0x400 x4, then 0x3F0 (1024-16).
REQ-024 Feed 0x80000000 and 0xFFFFF000 on fresh channels -> results 0x1FFFFFFF and 0x00000400; no overflow.
REQ-025 Drive start=1 continuously with a 4-channel sequence -> exactly one accept per IDLE cycle, one fin per accept, and chan wraps 3->0.
REQ-026 Assert env_clear during SCALE -> this op's fin/result normal (0x400); next op on channel 0 from a zero envelope.
REQ-027 Pulse RESET_N low during DIFF -> no fin pulse; idle_signal=1 immediately; all envelopes 0 afterwards.
